// File: rtl/if_stage_if.sv
// Handshake bundles used by the fetch stage: fetch request/response, issue to execute,
// control-flow resolution from execute, and the downstream flush pulse.

interface fch_req_if_t #(parameter int RV_PC_SIZE = 32);
  logic                  vld;
  logic                  rdy;
  logic [RV_PC_SIZE-1:0] pc;
  modport mst (output vld, output pc, input rdy);
  modport slv (input vld, input pc, output rdy);
endinterface

interface fch_rsp_if_t #(parameter int RV_IR_SIZE = 32);
  logic                  vld;
  logic                  rdy;
  logic [RV_IR_SIZE-1:0] ir;
  modport mst (output vld, output ir, input rdy);
  modport slv (input vld, input ir, output rdy);
endinterface

interface ex_req_if_t #(parameter int RV_PC_SIZE = 32, parameter int RV_IR_SIZE = 32);
  logic                  vld;
  logic                  rdy;
  logic [RV_IR_SIZE-1:0] ir;
  logic [RV_PC_SIZE-1:0] pc;
  logic                  pred_taken;
  logic [RV_PC_SIZE-1:0] pred_pc;
  modport mst (output vld, output ir, output pc, output pred_taken, output pred_pc, input rdy);
  modport slv (input vld, input ir, input pc, input pred_taken, input pred_pc, output rdy);
endinterface

interface ex_rsp_if_t #(parameter int RV_PC_SIZE = 32);
  logic                  vld;
  logic                  rdy;
  logic                  taken;
  logic                  pred_true;
  logic [RV_PC_SIZE-1:0] pc;
  logic [RV_PC_SIZE-1:0] target_pc;
  modport mst (output vld, output taken, output pred_true, output pc, output target_pc, input rdy);
  modport slv (input vld, input taken, input pred_true, input pc, input target_pc, output rdy);
endinterface

interface fl_req_if_t;
  logic vld;
  modport mst (output vld);
  modport slv (input vld);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding fetch, single-entry issue buffer, static prediction.
// RV_STATIC_BP_EN: when defined, backward conditional branches are predicted taken.
//
// state | meaning
// REQ   | presenting fetch address pc_r, waiting for fch_req handshake
// WAIT  | fetch accepted, waiting for the instruction word
// HOLD  | issue buffer valid, presenting it to execute
// DROP  | fetch outstanding but stale (redirected), discard its word

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst_n,
  fch_req_if_t.mst  fch_req,
  fch_rsp_if_t.slv  fch_rsp,
  ex_req_if_t.mst   ex_req,
  ex_rsp_if_t.slv   ex_rsp,
  fl_req_if_t.mst   fl_req
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_r, pc_nxt;
  logic [31:0] buf_ir, buf_pc, buf_pred_pc;
  logic        buf_pred_taken;
  logic        buf_ld;
  logic        flush_r;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [6:0]  opcode;
  logic [31:0] j_imm;
  logic        pred_taken;
  logic [31:0] pred_pc;
`ifdef RV_STATIC_BP_EN
  logic [31:0] b_imm;
`endif

  assign mispredict  = ex_rsp.vld && !ex_rsp.pred_true;
  assign redirect_pc = ex_rsp.taken ? ex_rsp.target_pc : ex_rsp.pc + 32'd4;
  assign opcode      = fch_rsp.ir[6:0];
  assign j_imm       = {{12{fch_rsp.ir[31]}}, fch_rsp.ir[19:12], fch_rsp.ir[20],
                        fch_rsp.ir[30:21], 1'b0};
`ifdef RV_STATIC_BP_EN
  assign b_imm       = {{20{fch_rsp.ir[31]}}, fch_rsp.ir[7], fch_rsp.ir[30:25],
                        fch_rsp.ir[11:8], 1'b0};
`endif

  // Prediction for the word currently arriving; only captured in WAIT, where pc_r is its address.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc_r + 32'd4;
    if (opcode == OP_JAL) begin
      pred_taken = 1'b1;
      pred_pc    = pc_r + j_imm;
    end
`ifdef RV_STATIC_BP_EN
    else if (opcode == OP_BRANCH && fch_rsp.ir[31]) begin
      pred_taken = 1'b1;
      pred_pc    = pc_r + b_imm;
    end
`else
    else if (opcode == OP_BRANCH) begin
      pred_taken = 1'b0;
    end
`endif
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_r;
    buf_ld      = 1'b0;
    fch_req.vld = 1'b0;
    fch_req.pc  = pc_r;
    fch_rsp.rdy = 1'b0;
    ex_req.vld  = 1'b0;
    case (state)
      S_REQ: begin
        fch_req.vld = 1'b1;
        if (mispredict) begin
          pc_nxt    = redirect_pc;
          state_nxt = fch_req.rdy ? S_DROP : S_REQ;
        end else if (fch_req.rdy) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        fch_rsp.rdy = 1'b1;
        if (mispredict) begin
          pc_nxt    = redirect_pc;
          state_nxt = fch_rsp.vld ? S_REQ : S_DROP;
        end else if (fch_rsp.vld) begin
          buf_ld    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        ex_req.vld = 1'b1;
        // A same-cycle redirect beats the issue handshake; the flush kills the issued word.
        if (mispredict) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (ex_req.rdy) begin
          pc_nxt    = buf_pred_pc;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        fch_rsp.rdy = 1'b1;
        if (mispredict) begin
          pc_nxt = redirect_pc;
        end
        // Once the stale word is consumed nothing is outstanding, so refetch even on a redirect.
        if (fch_rsp.vld) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_REQ;
      pc_r    <= RESET_PC;
      flush_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_r    <= pc_nxt;
      flush_r <= mispredict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_ir         <= 32'h0;
      buf_pc         <= 32'h0;
      buf_pred_pc    <= 32'h0;
      buf_pred_taken <= 1'b0;
    end else if (buf_ld) begin
      buf_ir         <= fch_rsp.ir;
      buf_pc         <= pc_r;
      buf_pred_pc    <= pred_pc;
      buf_pred_taken <= pred_taken;
    end
  end

  assign ex_req.ir         = buf_ir;
  assign ex_req.pc         = buf_pc;
  assign ex_req.pred_taken = buf_pred_taken;
  assign ex_req.pred_pc    = buf_pred_pc;
  assign ex_rsp.rdy        = 1'b1;
  assign fl_req.vld        = flush_r;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: random memory/execute behaviour plus directed redirect,
// stall and reset scenarios, checked against an address-level model of the program.

module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        tk;
    logic [31:0] ppc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fch_req_if_t fch_req ();
  fch_rsp_if_t fch_rsp ();
  ex_req_if_t  ex_req ();
  ex_rsp_if_t  ex_rsp ();
  fl_req_if_t  fl_req ();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fch_req (fch_req),
    .fch_rsp (fch_rsp),
    .ex_req  (ex_req),
    .ex_rsp  (ex_rsp),
    .fl_req  (fl_req)
  );

  int total = 0;
  int bad   = 0;
  int n_iss = 0;

  exp_t        q[$];
  logic [31:0] model_pc = RST_PC;

  int          mem_lat_min = 0;
  int          mem_lat_max = 2;
  int          ex_rdy_pct  = 70;
  bit          rand_rsp    = 1'b0;
  bit          force_ex_rdy0 = 1'b0;
  bit          inj_pend    = 1'b0;
  logic [31:0] inj_target  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd2, 5'd3, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  // Program image: each address holds a known kind of instruction with a known offset,
  // so the expected prediction follows from the kind, not from decoding bits.
  task automatic mem_info(input logic [31:0] a, output logic [31:0] ir,
                          output logic tk, output logic [31:0] ppc);
    logic [31:0] h;
    int          sel;
    int          off;
    int          kind;   // 0 other, 1 jal, 2 branch
    h    = (a >> 2) * 32'h9E37_79B1;
    sel  = int'(h[31:28]);
    off  = (int'(h[12:8]) - 16) * 4;
    kind = 0;
    ir   = {h[27:16], 20'h00013};
    if (a == 32'h100) begin
      ir = 32'h0000_0013;
    end else if (a == 32'h200) begin
      ir = 32'h0400_006F; kind = 1; off = 64;
    end else if (a == 32'h300) begin
      ir = 32'hFE00_0CE3; kind = 2; off = -8;
    end else if (sel >= 9 && sel <= 11) begin
      ir = enc_jal(off); kind = 1;
    end else if (sel >= 12 && sel <= 13) begin
      ir = enc_br(off); kind = 2;
    end else if (sel == 14) begin
      ir = {h[27:16], 20'h000E7};
    end else if (sel == 15) begin
      ir = {h[27:8], 12'h0B7};
    end
    tk  = 1'b0;
    ppc = a + 32'd4;
    if (kind == 1) begin
      tk  = 1'b1;
      ppc = a + off;
    end
`ifdef RV_STATIC_BP_EN
    if (kind == 2 && off < 0) begin
      tk  = 1'b1;
      ppc = a + off;
    end
`endif
  endtask

  // Driver: memory responder, execute back-pressure / resolution, and the expected-issue producer.
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;

  initial begin
    fch_req.rdy = 1'b0;
    fch_rsp.vld = 1'b0;
    fch_rsp.ir  = 32'h0;
    ex_req.rdy  = 1'b0;
    ex_rsp.vld  = 1'b0;
    ex_rsp.taken = 1'b0;
    ex_rsp.pred_true = 1'b1;
    ex_rsp.pc   = 32'h0;
    ex_rsp.target_pc = 32'h0;
  end

  always begin
    logic        hs_fch, hs_rsp, mis;
    logic [31:0] a, redir, ir_d, ppc_d;
    logic        tk_d;
    exp_t        e;
    @(negedge clk);
    hs_fch = fch_req.vld && fch_req.rdy;
    a      = fch_req.pc;
    hs_rsp = fch_rsp.vld && fch_rsp.rdy;
    mis    = ex_rsp.vld && !ex_rsp.pred_true;
    redir  = ex_rsp.taken ? ex_rsp.target_pc : ex_rsp.pc + 32'd4;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mem_pend    = 1'b0;
      fch_rsp.vld = 1'b0;
      fch_req.rdy = 1'b0;
      ex_rsp.vld  = 1'b0;
      q.delete();
      model_pc    = RST_PC;
    end else begin
      if (mis) begin
        q.delete();
        model_pc = redir;
      end
      if (hs_rsp) begin
        mem_pend    = 1'b0;
        fch_rsp.vld = 1'b0;
      end
      if (hs_fch) begin
        mem_pend = 1'b1;
        mem_addr = a;
        mem_cnt  = $urandom_range(mem_lat_max, mem_lat_min);
      end
      if (mem_pend && !fch_rsp.vld) begin
        if (mem_cnt == 0) begin
          mem_info(mem_addr, ir_d, tk_d, ppc_d);
          fch_rsp.vld = 1'b1;
          fch_rsp.ir  = ir_d;
        end else begin
          mem_cnt--;
        end
      end
      fch_req.rdy = !mem_pend && ($urandom_range(99, 0) < 70);
      ex_req.rdy  = !force_ex_rdy0 && ($urandom_range(99, 0) < ex_rdy_pct);
      ex_rsp.vld  = 1'b0;
      if (inj_pend) begin
        ex_rsp.vld       = 1'b1;
        ex_rsp.pred_true = 1'b0;
        ex_rsp.taken     = 1'b1;
        ex_rsp.target_pc = inj_target;
        ex_rsp.pc        = 32'h0;
        inj_pend         = 1'b0;
      end else if (rand_rsp && $urandom_range(99, 0) < 8) begin
        ex_rsp.vld       = 1'b1;
        ex_rsp.pred_true = $urandom_range(1, 0) == 1;
        ex_rsp.taken     = $urandom_range(1, 0) == 1;
        ex_rsp.target_pc = 32'($urandom_range(1023, 0)) << 2;
        ex_rsp.pc        = 32'($urandom_range(1023, 0)) << 2;
      end
      if (q.size() == 0) begin
        mem_info(model_pc, ir_d, tk_d, ppc_d);
        e.pc  = model_pc;
        e.ir  = ir_d;
        e.tk  = tk_d;
        e.ppc = ppc_d;
        q.push_back(e);
        model_pc = ppc_d;
      end
    end
  end

  // Monitor: handshake-driven scoreboard plus protocol checks.
  logic        prev_mis = 1'b0;
  logic        prev_fstall = 1'b0;
  logic        prev_estall = 1'b0;
  logic [31:0] prev_fpc = 32'h0;
  logic [96:0] prev_epkt = '0;

  always @(negedge clk) begin
    logic        mis;
    logic [96:0] epkt;
    exp_t        e;
    if (!rst_n) begin
      prev_mis    = 1'b0;
      prev_fstall = 1'b0;
      prev_estall = 1'b0;
    end else begin
      mis  = ex_rsp.vld && !ex_rsp.pred_true;
      epkt = {ex_req.pc, ex_req.ir, ex_req.pred_taken, ex_req.pred_pc};
      chk("flush_pulse", 32'(fl_req.vld), 32'(prev_mis));
      chk("one_outstanding", 32'(fch_req.vld && ex_req.vld), 32'd0);
      chk("ex_rsp_rdy", 32'(ex_rsp.rdy), 32'd1);
      if (prev_fstall) begin
        chk("fch_vld_hold", 32'(fch_req.vld), 32'd1);
        chk("fch_pc_stable", fch_req.pc, prev_fpc);
      end
      if (prev_estall) begin
        chk("ex_vld_hold", 32'(ex_req.vld), 32'd1);
        chk("ex_pkt_stable_pc", epkt[96:65], prev_epkt[96:65]);
        chk("ex_pkt_stable_ir", epkt[64:33], prev_epkt[64:33]);
        chk("ex_pkt_stable_pred", epkt[32:0] == prev_epkt[32:0], 32'd1);
      end
      if (fch_req.vld && fch_req.rdy && !mis) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_pc actual=%h required=<no expected entry>", fch_req.pc);
        end else begin
          chk("fetch_pc", fch_req.pc, q[0].pc);
        end
      end
      if (ex_req.vld && ex_req.rdy && !mis) begin
        n_iss++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL issue actual=%h required=<no expected entry>", ex_req.pc);
        end else begin
          e = q.pop_front();
          chk("issue_pc", ex_req.pc, e.pc);
          chk("issue_ir", ex_req.ir, e.ir);
          chk("issue_pred_taken", 32'(ex_req.pred_taken), 32'(e.tk));
          chk("issue_pred_pc", ex_req.pred_pc, e.ppc);
        end
      end
      prev_mis    = mis;
      prev_fstall = fch_req.vld && !fch_req.rdy && !mis;
      prev_estall = ex_req.vld && !ex_req.rdy && !mis;
      prev_fpc    = fch_req.pc;
      prev_epkt   = epkt;
    end
  end

  task automatic wait_fch_hs(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fch_req.vld && fch_req.rdy) && n < 200);
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL %s actual=timeout required=fetch handshake", nm);
    end
  endtask

  task automatic inject(input logic [31:0] tgt);
    inj_target = tgt;
    inj_pend   = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ex_vld", 32'(ex_req.vld), 32'd0);
    chk("rst_fch_rsp_rdy", 32'(fch_rsp.rdy), 32'd0);
    chk("rst_fl_vld", 32'(fl_req.vld), 32'd0);
    chk("rst_ex_rsp_rdy", 32'(ex_rsp.rdy), 32'd1);
    chk("rst_fch_pc", fch_req.pc, RST_PC);
    rst_n = 1'b1;
    #1;
    chk("post_rst_fch_vld", 32'(fch_req.vld), 32'd1);
    repeat (40) @(posedge clk);

    inject(32'h200);
    repeat (30) @(posedge clk);
    inject(32'h300);
    repeat (30) @(posedge clk);

    mem_lat_min = 3;
    mem_lat_max = 3;
    wait_fch_hs("wait_for_fetch_redirect");
    inject(32'h500);
    mem_lat_min = 0;
    mem_lat_max = 2;
    repeat (30) @(posedge clk);

    force_ex_rdy0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ex_req.vld && n < 200);
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL hold_reach actual=timeout required=ex_req.vld");
    end
    repeat (5) begin
      @(negedge clk);
      chk("hold_no_fetch", 32'(fch_req.vld), 32'd0);
      chk("hold_ex_vld", 32'(ex_req.vld), 32'd1);
    end
    force_ex_rdy0 = 1'b0;
    repeat (20) @(posedge clk);

    rand_rsp = 1'b1;
    repeat (3000) @(posedge clk);
    rand_rsp = 1'b0;
    repeat (20) @(posedge clk);

    mem_lat_min = 3;
    mem_lat_max = 3;
    wait_fch_hs("wait_for_fetch_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midfetch_rst_pc", fch_req.pc, RST_PC);
    chk("midfetch_rst_rsp_rdy", 32'(fch_rsp.rdy), 32'd0);
    chk("midfetch_rst_fl", 32'(fl_req.vld), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    mem_lat_min = 0;
    mem_lat_max = 2;
    n_iss = 0;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    chk("issued_after_reset", 32'(n_iss > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
